mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- MEM stage plus MEM/WB pipeline register of the 5-stage MIPS32 core.
- Consumes the EX/MEM register outputs (control, ALU result as address, write-back select, store data).
- Performs word load/store over a valid/ready data bus and stalls the upstream stages while the access is outstanding.
- Registers the write-back triple (reg_wr, waddr, wdata) for the WB stage.

Parameters:
- TIMEOUT_CYCLES, 255, max REQ-state cycles before abort (used only with MEM_TIMEOUT_EN); legal 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_reg_wr  in  1  register write enable from EX/MEM
- mem_mem_wr  in  1  store enable from EX/MEM
- mem_alu_result  in  32  ALU result / effective address
- mem_waddr  in  5  destination register
- mem_reg_wb_src  in  2  write-back select: 2'b00 ALU result, 2'b01 memory data, others treated as ALU result
- mem_store_data  in  32  rt value for stores
- dbus_req  out  1  bus request (registered)
- dbus_we  out  1  1 = write (registered)
- dbus_addr  out  32  word address (registered)
- dbus_wdata  out  32  store data (registered)
- dbus_ready  in  1  bus completion; rdata valid same cycle
- dbus_rdata  in  32  load data
- stall_req  out  1  hold PC/IF/ID/EX and EX/MEM (combinational)
- misalign  out  1  one-cycle pulse: misaligned access dropped (registered)
- bus_err  out  1  one-cycle pulse: bus timeout (registered; tied 0 without macro)
- wb_reg_wr  out  1  registered write enable to WB
- wb_waddr  out  5  registered destination
- wb_wdata  out  32  registered write data

Behaviour:
- Decode: load = (mem_reg_wb_src==2'b01) & !mem_mem_wr; store = mem_mem_wr; memop = (load|store) & (mem_alu_result[1:0]==0).
- Misaligned access: (load|store) with addr[1:0]!=0.
- Reset (synchronous): state IDLE; dbus_req=0, dbus_we=0, dbus_addr=0, dbus_wdata=0, misalign=0, bus_err=0, wb_reg_wr=0, wb_waddr=0, wb_wdata=0, timeout counter=0.
- Reset mid-access: dbus_req drops at that edge; no write-back; state IDLE.
- FSM states: IDLE, REQ.
- IDLE, memop:
  - stall_req=1.
  - Next edge: dbus_req<=1, dbus_we<=store, dbus_addr<=mem_alu_result, dbus_wdata<=mem_store_data.
  - wb_reg_wr<=0 (bubble); state->REQ.
- IDLE, non-memop aligned:
  - stall_req=0.
  - Next edge: wb_reg_wr<=mem_reg_wr, wb_waddr<=mem_waddr, wb_wdata<=mem_alu_result.
- IDLE, misaligned:
  - stall_req=0; no bus access.
  - Next edge: wb_reg_wr<=0, misalign<=1.
- REQ, dbus_ready=0:
  - stall_req=1; dbus_req and address/data held stable; wb_reg_wr<=0.
- REQ, dbus_ready=1:
  - stall_req=0.
  - Next edge: dbus_req<=0; wb_reg_wr<=mem_reg_wr & load; wb_waddr<=mem_waddr; wb_wdata<=(load ? dbus_rdata : mem_alu_result); state->IDLE.
- Latency:
  - Non-memop: result at WB 1 cycle after entry.
  - Memop with zero-wait bus: 2 cycles in stage (1 stall cycle).
  - Each wait cycle adds 1.
- Back-to-back memops:
  - The next instruction enters in the IDLE cycle after completion.
  - dbus_req is low for at least 1 cycle between requests.
- dbus_ready is ignored in IDLE.
- Upstream inputs are guaranteed stable while stall_req=1.
- misalign and bus_err are single-cycle pulses, cleared the following edge.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on REQ entry and increments each REQ cycle without dbus_ready.
  - When the counter equals TIMEOUT_CYCLES-1 and dbus_ready=0: next edge dbus_req<=0, state->IDLE, bus_err<=1, wb_reg_wr<=0; stall_req=0 that cycle.
  - If dbus_ready=1 in the same cycle, the completion wins (no bus_err).
- Undefined: no counter; REQ waits indefinitely; bus_err constant 0.

Test Plan:
- Reset with dbus_req held via prior load, rst=1 one edge -> dbus_req=0, wb_reg_wr=0, wb_wdata=0, state IDLE.
- ALU op reg_wr=1, waddr=5, alu_result=0x1234, wb_src=00 -> next edge wb_reg_wr=1, wb_waddr=5, wb_wdata=0x1234, stall_req never high.
- Load addr=0x100, waddr=8, bus ready after 3 wait cycles with rdata=0xDEADBEEF -> stall_req high 4 cycles; dbus_addr=0x100 stable; then wb_reg_wr=1, wb_waddr=8, wb_wdata=0xDEADBEEF.
- Store addr=0x20, data=0xCAFEF00D, zero-wait ready -> dbus_we=1, dbus_wdata=0xCAFEF00D for 1 cycle, wb_reg_wr=0; back-to-back load to 0x24 -> dbus_req low 1 cycle between requests.
- Load at addr=0x102 -> no dbus_req, misalign pulse 1 cycle, wb_reg_wr=0, no stall.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, dbus_ready held 0 -> bus_err pulses after 4 REQ cycles, dbus_req drops, stall_req releases; repeat with ready in cycle 4 -> normal completion, no bus_err.

Source files
------------

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
//
// MEM stage of the 5-stage MIPS32 core together with the MEM/WB pipeline
// register. Word loads and stores from the EX/MEM register are carried out
// over a valid/ready data bus. The upstream stages are held through stall_req
// while an access is outstanding. The write-back triple is registered for WB.
//
// Optional build macro:
//   MEM_TIMEOUT_EN - abort a bus request that has waited TIMEOUT_CYCLES REQ
//                    cycles without dbus_ready, and pulse bus_err. Without
//                    the macro a request waits indefinitely and bus_err is 0.
//
// Parameters:
//   TIMEOUT_CYCLES - REQ-state cycles before abort (1..65535). Only used
//                    with MEM_TIMEOUT_EN.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   mem_reg_wr      - register write enable from EX/MEM
//   mem_mem_wr      - store enable from EX/MEM
//   mem_alu_result  - ALU result, also the effective address
//   mem_waddr       - destination register
//   mem_reg_wb_src  - write-back select (01 = memory data, else ALU result)
//   mem_store_data  - rt value for stores
//   dbus_req/we/addr/wdata - registered data-bus request
//   dbus_ready      - bus completion, dbus_rdata valid in the same cycle
//   dbus_rdata      - load data
//   stall_req       - combinational hold for PC/IF/ID/EX and EX/MEM
//   misalign        - one-cycle pulse: misaligned access dropped
//   bus_err         - one-cycle pulse: bus timeout
//   wb_reg_wr/waddr/wdata - registered write-back to WB
// -----------------------------------------------------------------------------
module mem_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_reg_wr,
    input  logic        mem_mem_wr,
    input  logic [31:0] mem_alu_result,
    input  logic [4:0]  mem_waddr,
    input  logic [1:0]  mem_reg_wb_src,
    input  logic [31:0] mem_store_data,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ready,
    input  logic [31:0] dbus_rdata,
    output logic        stall_req,
    output logic        misalign,
    output logic        bus_err,
    output logic        wb_reg_wr,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t state;

    logic load;
    logic store;
    logic access;
    logic aligned;
    logic memop;
    logic misaligned;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_access: TIMEOUT_CYCLES must be in 1..65535");
    end

    // A store wins over a memory write-back select: mem_mem_wr alone makes it
    // a store, and only a non-store with wb_src 01 is a load.
    assign load       = (mem_reg_wb_src == 2'b01) & ~mem_mem_wr;
    assign store      = mem_mem_wr;
    assign access     = load | store;
    assign aligned    = (mem_alu_result[1:0] == 2'b00);
    assign memop      = access & aligned;
    assign misaligned = access & ~aligned;

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;
    logic        timeout_hit;

    // A completion in the last allowed cycle takes priority over the abort.
    assign timeout_hit = (tmo_cnt == TMO_LAST) & ~dbus_ready;

    assign stall_req = (state == IDLE) ? memop : (~dbus_ready & ~timeout_hit);
`else
    assign stall_req = (state == IDLE) ? memop : ~dbus_ready;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_wdata <= '0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
            wb_reg_wr  <= 1'b0;
            wb_waddr   <= '0;
            wb_wdata   <= '0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            // Status pulses last exactly one cycle.
            misalign <= 1'b0;
            bus_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (memop) begin
                        // Launch the bus request; the instruction stays in
                        // this stage, so WB sees a bubble meanwhile.
                        dbus_req   <= 1'b1;
                        dbus_we    <= store;
                        dbus_addr  <= mem_alu_result;
                        dbus_wdata <= mem_store_data;
                        wb_reg_wr  <= 1'b0;
                        state      <= REQ;
`ifdef MEM_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                    end else if (misaligned) begin
                        // Dropped access: no bus traffic, no write-back.
                        wb_reg_wr <= 1'b0;
                        misalign  <= 1'b1;
                    end else begin
                        wb_reg_wr <= mem_reg_wr;
                        wb_waddr  <= mem_waddr;
                        wb_wdata  <= mem_alu_result;
                    end
                end

                REQ: begin
                    if (dbus_ready) begin
                        // Stores never write a register.
                        dbus_req  <= 1'b0;
                        wb_reg_wr <= mem_reg_wr & load;
                        wb_waddr  <= mem_waddr;
                        wb_wdata  <= load ? dbus_rdata : mem_alu_result;
                        state     <= IDLE;
`ifdef MEM_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        dbus_req  <= 1'b0;
                        bus_err   <= 1'b1;
                        wb_reg_wr <= 1'b0;
                        state     <= IDLE;
`endif
                    end else begin
                        // Request, address and data held stable while waiting.
                        wb_reg_wr <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        tmo_cnt   <= tmo_cnt + 16'd1;
`endif
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
//
// Scoreboard bench for mem_access. A driver issues one instruction at a time
// and pushes its expected write-back and stall count; a negedge monitor pops
// and compares when the instruction leaves the stage. A bus responder pops the
// expected bus request, checks it and answers after a chosen number of waits.
// Expected load data comes from a word-addressed reference memory.
// -----------------------------------------------------------------------------
module tb_mem_access;

    localparam int TMO = 4;
`ifdef MEM_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_reg_wr;
    logic        mem_mem_wr;
    logic [31:0] mem_alu_result;
    logic [4:0]  mem_waddr;
    logic [1:0]  mem_reg_wb_src;
    logic [31:0] mem_store_data;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic        dbus_ready;
    logic [31:0] dbus_rdata;
    logic        stall_req;
    logic        misalign;
    logic        bus_err;
    logic        wb_reg_wr;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_reg_wr     (mem_reg_wr),
        .mem_mem_wr     (mem_mem_wr),
        .mem_alu_result (mem_alu_result),
        .mem_waddr      (mem_waddr),
        .mem_reg_wb_src (mem_reg_wb_src),
        .mem_store_data (mem_store_data),
        .dbus_req       (dbus_req),
        .dbus_we        (dbus_we),
        .dbus_addr      (dbus_addr),
        .dbus_wdata     (dbus_wdata),
        .dbus_ready     (dbus_ready),
        .dbus_rdata     (dbus_rdata),
        .stall_req      (stall_req),
        .misalign       (misalign),
        .bus_err        (bus_err),
        .wb_reg_wr      (wb_reg_wr),
        .wb_waddr       (wb_waddr),
        .wb_wdata       (wb_wdata)
    );

    typedef struct {
        logic        reg_wr;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        misalign;
        logic        bus_err;
        int          stalls;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          w;
    } bus_t;

    exp_t        sb_q[$];
    bus_t        bus_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bus_mem [logic [31:0]];

    int errors   = 0;
    int checks   = 0;
    int n_issued = 0;
    int n_cmp    = 0;
    bit mon_en   = 1'b0;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : mem_init(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one instruction: compute its expected outcome, present it, and
    // hold it until the stage accepts it (stall_req low).
    task automatic issue(input logic rw, input logic mw, input logic [31:0] alu,
                         input logic [4:0] wa, input logic [1:0] src,
                         input logic [31:0] sd, input int w);
        exp_t e;
        bit   ld;
        bit   acc;
        int   cyc;
        ld  = (src == 2'b01) && !mw;
        acc = ld || mw;
        e.reg_wr = 1'b0; e.waddr = wa; e.wdata = alu;
        e.misalign = 1'b0; e.bus_err = 1'b0; e.stalls = 0;
        if (!acc) begin
            e.reg_wr = rw;
        end else if (alu[1:0] != 2'b00) begin
            e.misalign = 1'b1;
        end else begin
            bus_q.push_back('{alu, mw, sd, w});
            if (TMO_ON && w >= TMO) begin
                e.bus_err = 1'b1;
                e.stalls  = TMO;
            end else begin
                e.stalls = 1 + w;
                if (ld) begin
                    e.reg_wr = rw;
                    e.wdata  = ref_rd(alu);
                end else begin
                    ref_mem[alu] = sd;
                end
            end
        end
        sb_q.push_back(e);
        n_issued++;
        mem_reg_wr = rw; mem_mem_wr = mw; mem_alu_result = alu;
        mem_waddr = wa; mem_reg_wb_src = src; mem_store_data = sd;
        cyc = 0;
        @(negedge clk);
        while (stall_req && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        if (stall_req) begin
            checks++; errors++;
            $display("FAIL accept_timeout: stall_req still 1 after %0d cycles, expected release", cyc);
        end
        @(posedge clk); #1;
    endtask

    // Monitor: compare the write-back the cycle after each acceptance, and
    // require a bubble after every stall cycle.
    initial begin
        exp_t cur;
        bit   slot;
        int   stalls;
        slot = 1'b0; stalls = 0;
        cur.reg_wr = 1'b0; cur.waddr = '0; cur.wdata = '0;
        cur.misalign = 1'b0; cur.bus_err = 1'b0; cur.stalls = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                slot = 1'b0; stalls = 0;
            end else begin
                if (slot) begin
                    n_cmp++;
                    chk("wb_reg_wr", 32'(wb_reg_wr), 32'(cur.reg_wr));
                    chk("misalign", 32'(misalign), 32'(cur.misalign));
                    chk("bus_err", 32'(bus_err), 32'(cur.bus_err));
                    if (cur.reg_wr) begin
                        chk("wb_waddr", 32'(wb_waddr), 32'(cur.waddr));
                        chk("wb_wdata", wb_wdata, cur.wdata);
                    end
                end else begin
                    chk("bubble_reg_wr", 32'(wb_reg_wr), 32'd0);
                    chk("bubble_misalign", 32'(misalign), 32'd0);
                    chk("bubble_bus_err", 32'(bus_err), 32'd0);
                end
                if (stall_req) begin
                    stalls++;
                    slot = 1'b0;
                end else if (sb_q.size() > 0) begin
                    cur = sb_q.pop_front();
                    chk("stall_cycles", 32'(stalls), 32'(cur.stalls));
                    stalls = 0;
                    slot = 1'b1;
                end else begin
                    slot = 1'b0;
                    stalls = 0;
                end
            end
        end
    end

    // Bus responder: checks each request against the expected one and
    // asserts dbus_ready after the chosen number of wait cycles.
    initial begin
        bus_t cur;
        int   cnt;
        bit   in_req;
        logic rdy_last;
        in_req = 1'b0; cnt = 0; rdy_last = 1'b0;
        dbus_ready = 1'b0; dbus_rdata = '0;
        cur = '{32'd0, 1'b0, 32'd0, 1000};
        forever begin
            @(posedge clk); #1;
            if (!dbus_req) begin
                in_req = 1'b0;
                dbus_ready = 1'b0;
            end else begin
                chk("req_gap", 32'(rdy_last), 32'd0);
                if (!in_req) begin
                    in_req = 1'b1;
                    cnt = 0;
                    if (bus_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_req: got request to %h, expected none", dbus_addr);
                        cur = '{dbus_addr, dbus_we, dbus_wdata, 1000};
                    end else begin
                        cur = bus_q.pop_front();
                    end
                end else begin
                    cnt++;
                end
                chk("dbus_addr", dbus_addr, cur.addr);
                chk("dbus_we", 32'(dbus_we), 32'(cur.we));
                if (cur.we) chk("dbus_wdata", dbus_wdata, cur.wdata);
                if (cnt == cur.w) begin
                    dbus_ready = 1'b1;
                    if (cur.we) begin
                        bus_mem[cur.addr] = cur.wdata;
                        dbus_rdata = $urandom;
                    end else begin
                        dbus_rdata = bus_rd(cur.addr);
                    end
                    in_req = 1'b0;
                end else begin
                    dbus_ready = 1'b0;
                    dbus_rdata = $urandom;
                end
            end
            rdy_last = dbus_ready;
        end
    end

    // Driver
    initial begin
        int          kind;
        logic [31:0] a;
        logic [1:0]  src;
        logic        mw;
        int          w;

        rst = 1'b1;
        mem_reg_wr = 1'b0; mem_mem_wr = 1'b0; mem_alu_result = '0;
        mem_waddr = '0; mem_reg_wb_src = '0; mem_store_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dbus_req", 32'(dbus_req), 32'd0);
        chk("rst_dbus_we", 32'(dbus_we), 32'd0);
        chk("rst_dbus_addr", dbus_addr, 32'd0);
        chk("rst_dbus_wdata", dbus_wdata, 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_wb_reg_wr", 32'(wb_reg_wr), 32'd0);
        chk("rst_wb_waddr", 32'(wb_waddr), 32'd0);
        chk("rst_wb_wdata", wb_wdata, 32'd0);
        chk("rst_stall_req", 32'(stall_req), 32'd0);

        // Put non-zero data into WB, then reset in the middle of a load.
        rst = 1'b0;
        mem_reg_wr = 1'b1; mem_waddr = 5'd3; mem_alu_result = 32'hAAAA5555;
        @(posedge clk); #1;
        chk("pre_wb_reg_wr", 32'(wb_reg_wr), 32'd1);
        chk("pre_wb_wdata", wb_wdata, 32'hAAAA5555);
        bus_q.push_back('{32'h100, 1'b0, 32'd0, 20});
        mem_reg_wb_src = 2'b01; mem_alu_result = 32'h100; mem_waddr = 5'd8;
        @(posedge clk); #1;
        chk("midrst_req_up", 32'(dbus_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_dbus_req", 32'(dbus_req), 32'd0);
        chk("midrst_wb_reg_wr", 32'(wb_reg_wr), 32'd0);
        chk("midrst_wb_wdata", wb_wdata, 32'd0);
        chk("midrst_dbus_addr", dbus_addr, 32'd0);
        mem_reg_wr = 1'b0; mem_reg_wb_src = 2'b00; mem_alu_result = '0; mem_waddr = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Directed sequence.
        ref_mem[32'h100] = 32'hDEADBEEF;
        bus_mem[32'h100] = 32'hDEADBEEF;
        issue(1'b1, 1'b0, 32'h1234, 5'd5, 2'b00, 32'd0, 0);
        issue(1'b1, 1'b0, 32'h100, 5'd8, 2'b01, 32'd0, 3);
        issue(1'b1, 1'b1, 32'h20, 5'd0, 2'b00, 32'hCAFEF00D, 0);
        issue(1'b1, 1'b0, 32'h24, 5'd9, 2'b01, 32'd0, 0);
        issue(1'b1, 1'b0, 32'h20, 5'd10, 2'b01, 32'd0, 1);
        issue(1'b1, 1'b0, 32'h102, 5'd11, 2'b01, 32'd0, 0);
        issue(1'b1, 1'b0, 32'h77, 5'd12, 2'b10, 32'd0, 0);
`ifdef MEM_TIMEOUT_EN
        issue(1'b1, 1'b0, 32'h100, 5'd13, 2'b01, 32'd0, TMO + 2);
        issue(1'b1, 1'b0, 32'h100, 5'd14, 2'b01, 32'd0, TMO - 1);
`endif

        // Randomized sequence over a small address window.
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 9));
            a = 32'h200 + (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            w = TMO_ON ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 3));
            if (kind < 4) begin
                src = 2'b01; mw = 1'b0;
            end else if (kind < 7) begin
                src = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
                mw = 1'b0;
                a = $urandom;
            end else begin
                src = 2'($urandom_range(0, 3)); mw = 1'b1;
            end
            issue(1'($urandom_range(0, 3) != 0), mw, a, 5'($urandom), src, $urandom, w);
        end

        issue(1'b0, 1'b0, 32'd0, 5'd0, 2'b00, 32'd0, 0);
        @(negedge clk); #1;
        mon_en = 1'b0;

        chk("sb_queue_empty", 32'(sb_q.size()), 32'd0);
        chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);
        chk("wb_compares", 32'(n_cmp), 32'(n_issued));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
